// File: rtl/videobox_sys_pll_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : videobox_pll_seq_pkg
//  Brief    : Shared types for the system PLL reset sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package videobox_pll_seq_pkg;

  // Sequencer states; the encodings are visible on the state output port.
  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'b00,
    ST_WAIT_LOCK = 2'b01,
    ST_STABLE    = 2'b10,
    ST_RUN       = 2'b11
  } pll_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/videobox_bit_sync.sv
`default_nettype none
// ============================================================================
//  Module   : videobox_bit_sync
//  Brief    : Multi-flop synchronizer for a single asynchronous level.
//  Revision : 1.0 - initial release
// ============================================================================
module videobox_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/videobox_sys_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : videobox_sys_pll_reset_sequencer
//  Brief    : Pulses the PLL reset, supervises lock with timeout/retry and
//             releases the system reset only after lock has been stable.
//             Clocked by the PLL reference so it survives loss of lock.
//  Revision : 1.0 - initial release
// ============================================================================
module videobox_sys_pll_reset_sequencer
  import videobox_pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int STABLE_CYC       = 1024,
  parameter int CNT_W            = 20,
  parameter int ERR_W            = 8
) (
  input  logic             i_refclk,
  input  logic             i_rst,
  input  logic             i_pll_locked,
  input  logic             i_soft_rst_req,
  output logic             o_pll_rst,
  output logic             o_sys_rst,
  output logic             o_ready,
  output logic [1:0]       o_state,
  output logic [ERR_W-1:0] o_timeout_cnt,
  output logic [ERR_W-1:0] o_lockloss_cnt
);

  localparam logic [CNT_W-1:0] c_pll_rst_last = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(STABLE_CYC - 1);
  localparam logic [ERR_W-1:0] c_err_max      = '1;

  pll_seq_state_t   r_state;
  pll_seq_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic [ERR_W-1:0] r_timeout_cnt;
  logic [ERR_W-1:0] r_lockloss_cnt;
  logic             w_timeout_inc;
  logic             w_lockloss_inc;
  logic             w_lk;

  videobox_bit_sync #(
    .STAGES (2)
  ) u_lock_sync (
    .i_clk (i_refclk),
    .i_rst (i_rst),
    .i_d   (i_pll_locked),
    .o_q   (w_lk)
  );

  // Next-state, timer and event decode; a soft request overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer + CNT_W'(1);
    w_timeout_inc  = 1'b0;
    w_lockloss_inc = 1'b0;
    if (i_soft_rst_req) begin
      w_state_nxt = ST_PLL_RST;
      w_timer_nxt = '0;
    end else begin
      unique case (r_state)
        ST_PLL_RST: begin
          if (r_timer == c_pll_rst_last) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_timer_nxt = '0;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock seen on the terminal cycle beats the timeout.
          if (w_lk) begin
            w_state_nxt = ST_STABLE;
            w_timer_nxt = '0;
          end else if (r_timer == c_timeout_last) begin
            w_state_nxt   = ST_PLL_RST;
            w_timer_nxt   = '0;
            w_timeout_inc = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!w_lk) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_timer_nxt = '0;
          end else if (r_timer == c_stable_last) begin
            w_state_nxt = ST_RUN;
            w_timer_nxt = '0;
          end
        end
        ST_RUN: begin
          // Timer idles in RUN so it never wraps.
          w_timer_nxt = '0;
          if (!w_lk) begin
            w_state_nxt    = ST_PLL_RST;
            w_lockloss_inc = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_PLL_RST;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  // State, timer, registered outputs (decoded from next state) and counters.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_state        <= ST_PLL_RST;
      r_timer        <= '0;
      r_pll_rst      <= 1'b1;
      r_sys_rst      <= 1'b1;
      r_ready        <= 1'b0;
      r_timeout_cnt  <= '0;
      r_lockloss_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_pll_rst <= (w_state_nxt == ST_PLL_RST);
      r_sys_rst <= (w_state_nxt != ST_RUN);
      r_ready   <= (w_state_nxt == ST_RUN);
      if (w_timeout_inc && (r_timeout_cnt != c_err_max)) begin
        r_timeout_cnt <= r_timeout_cnt + ERR_W'(1);
      end
      if (w_lockloss_inc && (r_lockloss_cnt != c_err_max)) begin
        r_lockloss_cnt <= r_lockloss_cnt + ERR_W'(1);
      end
    end
  end

  assign o_pll_rst      = r_pll_rst;
  assign o_sys_rst      = r_sys_rst;
  assign o_ready        = r_ready;
  assign o_state        = r_state;
  assign o_timeout_cnt  = r_timeout_cnt;
  assign o_lockloss_cnt = r_lockloss_cnt;

endmodule
`default_nettype wire
